// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; training happens on the clock edge with one-cycle latency.
module branch_predictor #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_fetch,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_pc,
  input  logic        i_upd_vld,
  input  logic        i_upd_ctrl,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_mispred,
  output logic [31:0] o_ctrl_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_en;

  assign fetch_idx = i_pc_fetch[IDX_W+1:2];
  assign fetch_tag = i_pc_fetch[31:IDX_W+2];
  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  assign upd_idx = i_upd_pc[IDX_W+1:2];
  assign upd_tag = i_upd_pc[31:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_en  = i_upd_vld && i_upd_ctrl;

  // Reads see pre-edge array contents, so a same-cycle update is only visible next cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    o_pred_taken = 1'b0;
    o_pred_pc    = {i_pc_fetch[31:2] + 30'd1, i_pc_fetch[1:0]};
    if (fetch_hit && ctr_q[fetch_idx][1]) begin
      o_pred_taken = 1'b1;
      o_pred_pc    = target_q[fetch_idx];
    end
  end

  // NOTE: the table is held in flops with an async reset because every entry must clear
  // without a clock; a RAM macro could not meet that.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_en) begin
      // NOTE: non-blocking assignments keep state updates order-independent across blocks.
      if (upd_hit) begin
        if (i_upd_taken) begin
          target_q[upd_idx] <= i_upd_target;
          if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (i_upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= i_upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_ctrl_cnt    <= '0;
      o_mispred_cnt <= '0;
    end else if (upd_en) begin
      o_ctrl_cnt <= o_ctrl_cnt + 32'd1;
      if (i_upd_mispred) o_mispred_cnt <= o_mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset sweep, training, hysteresis, aliasing,
// same-cycle bypass, update gating, counter wrap and asynchronous reset.
module tb_branch_predictor;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_pc_fetch;
  logic        o_pred_taken;
  logic [31:0] o_pred_pc;
  logic        i_upd_vld;
  logic        i_upd_ctrl;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_mispred;
  logic [31:0] o_ctrl_cnt;
  logic [31:0] o_mispred_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_ctrl = 0;
  logic [31:0] exp_mis  = 0;

  branch_predictor #(.ENTRIES(32), .IDX_W(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pc_fetch(i_pc_fetch),
    .o_pred_taken(o_pred_taken), .o_pred_pc(o_pred_pc),
    .i_upd_vld(i_upd_vld), .i_upd_ctrl(i_upd_ctrl), .i_upd_pc(i_upd_pc),
    .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target),
    .i_upd_mispred(i_upd_mispred),
    .o_ctrl_cnt(o_ctrl_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Holds one update across exactly one rising edge, then idles the update port.
  task automatic do_upd(input logic vld, input logic ctrl, input logic [31:0] pc,
                        input logic taken, input logic [31:0] tgt, input logic mis);
    @(negedge i_clk);
    i_upd_vld = vld; i_upd_ctrl = ctrl; i_upd_pc = pc;
    i_upd_taken = taken; i_upd_target = tgt; i_upd_mispred = mis;
    @(negedge i_clk);
    i_upd_vld = 1'b0; i_upd_ctrl = 1'b0; i_upd_mispred = 1'b0;
    if (vld && ctrl) begin
      exp_ctrl++;
      if (mis) exp_mis++;
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b0;
    i_pc_fetch = 32'h40;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'h44) begin
      err_cnt++;
      $display("FAIL reset_during: taken=%0b pc=%h want 0/00000044", o_pred_taken, o_pred_pc);
    end
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    for (int a = 0; a <= 32'h1FC; a += 4) begin
      i_pc_fetch = a;
      #1;
      vec_cnt++;
      if (o_pred_taken !== 1'b0 || o_pred_pc !== a + 4) begin
        err_cnt++;
        $display("FAIL reset_sweep pc=%h: taken=%0b npc=%h want 0/%h", a, o_pred_taken,
                 o_pred_pc, a + 4);
      end
    end
    vec_cnt++;
    if (o_ctrl_cnt !== 32'd0 || o_mispred_cnt !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_counters: ctrl=%0d mis=%0d want 0/0", o_ctrl_cnt, o_mispred_cnt);
    end
  endtask

  task automatic test_train_taken;
    do_upd(1, 1, 32'h40, 1, 32'h100, 1);
    i_pc_fetch = 32'h40;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b1 || o_pred_pc !== 32'h100) begin
      err_cnt++;
      $display("FAIL train_taken: taken=%0b pc=%h want 1/00000100", o_pred_taken, o_pred_pc);
    end
    vec_cnt++;
    if (o_ctrl_cnt !== 32'd1 || o_mispred_cnt !== 32'd1) begin
      err_cnt++;
      $display("FAIL train_counters: ctrl=%0d mis=%0d want 1/1", o_ctrl_cnt, o_mispred_cnt);
    end
  endtask

  task automatic test_hysteresis;
    // counter 10 -> 01 -> 00 -> 00, then 01 -> 10
    logic        dir  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        want [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] wpc  [5] = '{32'h44, 32'h44, 32'h44, 32'h44, 32'h180};
    for (int k = 0; k < 5; k++) begin
      do_upd(1, 1, 32'h40, dir[k], 32'h180, 1'b0);
      i_pc_fetch = 32'h40;
      #1;
      vec_cnt++;
      if (o_pred_taken !== want[k] || o_pred_pc !== wpc[k]) begin
        err_cnt++;
        $display("FAIL hysteresis step %0d: taken=%0b pc=%h want %0b/%h", k, o_pred_taken,
                 o_pred_pc, want[k], wpc[k]);
      end
    end
  endtask

  task automatic test_alias;
    i_pc_fetch = 32'hC0;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'hC4) begin
      err_cnt++;
      $display("FAIL alias_miss: taken=%0b pc=%h want 0/000000c4", o_pred_taken, o_pred_pc);
    end
    do_upd(1, 1, 32'hC0, 1, 32'h200, 1);
    i_pc_fetch = 32'hC0;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b1 || o_pred_pc !== 32'h200) begin
      err_cnt++;
      $display("FAIL alias_alloc: taken=%0b pc=%h want 1/00000200", o_pred_taken, o_pred_pc);
    end
    i_pc_fetch = 32'h40;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'h44) begin
      err_cnt++;
      $display("FAIL alias_evict: taken=%0b pc=%h want 0/00000044", o_pred_taken, o_pred_pc);
    end
  endtask

  task automatic test_same_cycle;
    @(negedge i_clk);
    i_pc_fetch = 32'h80;
    i_upd_vld = 1; i_upd_ctrl = 1; i_upd_pc = 32'h80;
    i_upd_taken = 1; i_upd_target = 32'h300; i_upd_mispred = 0;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'h84) begin
      err_cnt++;
      $display("FAIL same_cycle_old: taken=%0b pc=%h want 0/00000084", o_pred_taken, o_pred_pc);
    end
    @(negedge i_clk);
    i_upd_vld = 0; i_upd_ctrl = 0;
    exp_ctrl++;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b1 || o_pred_pc !== 32'h300) begin
      err_cnt++;
      $display("FAIL same_cycle_new: taken=%0b pc=%h want 1/00000300", o_pred_taken, o_pred_pc);
    end
  endtask

  task automatic test_gating;
    do_upd(0, 1, 32'h100, 1, 32'h400, 1);
    do_upd(1, 0, 32'h100, 1, 32'h400, 1);
    do_upd(0, 1, 32'h80, 0, 32'h0, 1);
    i_pc_fetch = 32'h100;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'h104) begin
      err_cnt++;
      $display("FAIL gated_no_alloc: taken=%0b pc=%h want 0/00000104", o_pred_taken, o_pred_pc);
    end
    i_pc_fetch = 32'h80;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b1 || o_pred_pc !== 32'h300) begin
      err_cnt++;
      $display("FAIL gated_no_train: taken=%0b pc=%h want 1/00000300", o_pred_taken, o_pred_pc);
    end
    vec_cnt++;
    if (o_ctrl_cnt !== exp_ctrl || o_mispred_cnt !== exp_mis) begin
      err_cnt++;
      $display("FAIL gated_counters: ctrl=%0d mis=%0d want %0d/%0d", o_ctrl_cnt,
               o_mispred_cnt, exp_ctrl, exp_mis);
    end
    // Not-taken miss counts as resolved control but allocates nothing.
    do_upd(1, 1, 32'h104, 0, 32'h500, 0);
    i_pc_fetch = 32'h104;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'h108 || o_ctrl_cnt !== exp_ctrl) begin
      err_cnt++;
      $display("FAIL nt_miss: taken=%0b pc=%h ctrl=%0d want 0/00000108/%0d", o_pred_taken,
               o_pred_pc, o_ctrl_cnt, exp_ctrl);
    end
  endtask

  task automatic test_wrap;
    @(negedge i_clk);
    force dut.o_mispred_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.o_mispred_cnt;
    exp_mis = 32'hFFFF_FFFF;
    do_upd(1, 1, 32'h80, 1, 32'h300, 1);
    #1;
    vec_cnt++;
    if (o_mispred_cnt !== exp_mis || o_mispred_cnt !== 32'd0) begin
      err_cnt++;
      $display("FAIL mispred_wrap: got %h want 00000000", o_mispred_cnt);
    end
  endtask

  task automatic test_async_reset;
    // Reset asserted mid-cycle while an update is held across the following edge.
    @(posedge i_clk);
    #2;
    i_upd_vld = 1; i_upd_ctrl = 1; i_upd_pc = 32'h140;
    i_upd_taken = 1; i_upd_target = 32'h600; i_upd_mispred = 1;
    i_pc_fetch = 32'h80;
    i_reset = 1'b0;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'h84 || o_ctrl_cnt !== 32'd0 ||
        o_mispred_cnt !== 32'd0) begin
      err_cnt++;
      $display("FAIL async_reset: taken=%0b pc=%h ctrl=%0d mis=%0d want 0/00000084/0/0",
               o_pred_taken, o_pred_pc, o_ctrl_cnt, o_mispred_cnt);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_upd_vld = 0; i_upd_ctrl = 0; i_upd_mispred = 0;
    i_reset = 1'b1;
    i_pc_fetch = 32'h140;
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'h144 || o_ctrl_cnt !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_discard: taken=%0b pc=%h ctrl=%0d want 0/00000144/0",
               o_pred_taken, o_pred_pc, o_ctrl_cnt);
    end
    exp_ctrl = 0; exp_mis = 0;
    do_upd(1, 1, 32'h140, 1, 32'h600, 0);
    #1;
    vec_cnt++;
    if (o_pred_taken !== 1'b1 || o_pred_pc !== 32'h600 || o_ctrl_cnt !== exp_ctrl) begin
      err_cnt++;
      $display("FAIL post_reset_train: taken=%0b pc=%h ctrl=%0d want 1/00000600/%0d",
               o_pred_taken, o_pred_pc, o_ctrl_cnt, exp_ctrl);
    end
  endtask

  initial begin
    i_upd_vld = 0; i_upd_ctrl = 0; i_upd_pc = 0;
    i_upd_taken = 0; i_upd_target = 0; i_upd_mispred = 0;
    test_reset();
    test_train_taken();
    test_hysteresis();
    test_alias();
    test_same_cycle();
    test_gating();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
